input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples required to accept a level change; legal range 1..(2**CNT_W).
REQ-002 Parameter CNT_W, default 5, debounce counter width.
REQ-003 Parameter GLITCH_W, default 8, glitch counter width; used only when the Configuration macro is defined.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  1  raw asynchronous input (switch or external line).
REQ-007 x1  output  1  debounced registered level; drives the x1 input of the downstream FSM.
REQ-008 x1_rise  output  1  one-cycle pulse, coincident with the first cycle x1=1.
REQ-009 x1_fall  output  1  one-cycle pulse, coincident with the first cycle x1=0.
REQ-010 glitch_cnt  output  GLITCH_W  count of rejected transitions; present only when the Configuration macro is defined.

Function
REQ-011 din SHALL pass through a 2-flop synchronizer (s1, then s2); only s2 feeds the state machine.
REQ-012 The state machine SHALL have four states: LOW, RISE_WAIT, HIGH, FALL_WAIT.
REQ-013 LOW: s2=1 -> RISE_WAIT with cnt=0; otherwise hold.
REQ-014 RISE_WAIT: s2=0 -> LOW (glitch); s2=1 and cnt=DEBOUNCE_CYCLES-1 -> HIGH; s2=1 otherwise -> cnt+1.
REQ-015 HIGH: s2=0 -> FALL_WAIT with cnt=0; otherwise hold.
REQ-016 FALL_WAIT: s2=1 -> HIGH (glitch); s2=0 and cnt=DEBOUNCE_CYCLES-1 -> LOW; s2=0 otherwise -> cnt+1.
REQ-017 x1 SHALL be 1 exactly while the state is HIGH or FALL_WAIT, and SHALL be registered (no combinational path from din).
REQ-018 Latency: din first sampled 1 at edge N and held -> x1=1 after edge N+2+DEBOUNCE_CYCLES; falling edge symmetric.
REQ-019 x1_rise SHALL be 1 for exactly the one cycle following the RISE_WAIT->HIGH transition; x1_fall likewise for FALL_WAIT->LOW; the two are never 1 together.
REQ-020 A glitch (REQ-014/REQ-016 return path) SHALL leave x1 unchanged and SHALL generate no pulse.
REQ-021 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.
REQ-022 DEBOUNCE_CYCLES=1: a single stable s2 sample in a WAIT state SHALL complete the transition.

Reset
REQ-023 reset=1 at a clock edge SHALL force s1=0, s2=0, state=LOW, cnt=0, x1=0, x1_rise=0, x1_fall=0, glitch_cnt=0 on the next cycle.
REQ-024 Reset SHALL dominate all other inputs; reset asserted while in HIGH or FALL_WAIT SHALL drop x1 to 0 with no x1_fall pulse.
REQ-025 After reset release with din=1 held, x1 SHALL rise per REQ-018, counting from the first post-reset sample.

Configuration
REQ-026 With macro INPUT_CONDITIONER_GLITCH_CNT_EN defined, port glitch_cnt SHALL exist and SHALL increment by 1 on each glitch return (RISE_WAIT->LOW or FALL_WAIT->HIGH), saturating at 2**GLITCH_W-1.
REQ-027 Without INPUT_CONDITIONER_GLITCH_CNT_EN, port glitch_cnt and its register SHALL be absent; all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES=16 unless stated)
REQ-028 Reset, then din=1 from edge 10 held -> x1=1 and x1_rise=1 for one cycle after edge 28; x1_fall stays 0.
REQ-029 From stable HIGH, din=0 held from edge 100 -> x1=0 and x1_fall=1 for one cycle after edge 118.
REQ-030 From LOW, din=1 for 5 cycles then 0 -> x1 stays 0, no pulses; glitch_cnt=1 with macro defined.
REQ-031 Chatter: din toggles every 3 cycles for 60 cycles, then held 1 -> x1 rises exactly once, 18 cycles after the last 0->1 sample; glitch_cnt equals the number of aborted waits (saturates at 255 when forced past it).
REQ-032 In HIGH, reset pulsed 1 cycle -> x1=0 next cycle, no x1_fall; with din still 1, x1 returns to 1 18 cycles after reset release.
REQ-033 DEBOUNCE_CYCLES=1, din=1 held from edge 5 -> x1=1 after edge 8.

Source files
------------

// File: rtl/input_conditioner.sv
// Purpose : synchronise and debounce a raw asynchronous level into x1, with
//           one-cycle rise/fall pulses for the downstream FSM.
// Latency : din held from edge N gives x1 updated after edge N+2+DEBOUNCE_CYCLES.
// Backpressure: none; free-running single-bit conditioner, no handshake.
// Ports   : clk, reset (sync, active-high), din (raw async input),
//           x1 (debounced registered level), x1_rise / x1_fall (one-cycle pulses),
//           glitch_cnt (rejected transitions, saturating) -- only with
//           INPUT_CONDITIONER_GLITCH_CNT_EN defined.
// Optional: define INPUT_CONDITIONER_GLITCH_CNT_EN to build the glitch counter.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int GLITCH_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic x1,
    output logic x1_rise,
    output logic x1_fall
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    // Reject parameter sets the counter cannot represent.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W)) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (GLITCH_W < 1) begin : g_bad_glitch_w
        $error("input_conditioner: GLITCH_W must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_LOW,
        ST_RISE_WAIT,
        ST_HIGH,
        ST_FALL_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            x1_q, x1_d;
    logic            x1_rise_q, x1_rise_d;
    logic            x1_fall_q, x1_fall_d;

    always_comb begin
        s1_d      = din;
        s2_d      = s1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        x1_rise_d = 1'b0;
        x1_fall_d = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (s2_q) begin
                    state_d = ST_RISE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RISE_WAIT: begin
                if (!s2_q) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_HIGH;
                    cnt_d     = '0;
                    x1_rise_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_FALL_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_FALL_WAIT: begin
                if (s2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_LOW;
                    cnt_d     = '0;
                    x1_fall_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
        // x1 is a decode of the next state so it is a flop output aligned with
        // the state register, not a combinational function of din.
        x1_d = (state_d == ST_HIGH) || (state_d == ST_FALL_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= ST_LOW;
            cnt_q     <= '0;
            x1_q      <= 1'b0;
            x1_rise_q <= 1'b0;
            x1_fall_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x1_q      <= x1_d;
            x1_rise_q <= x1_rise_d;
            x1_fall_q <= x1_fall_d;
        end
    end

    assign x1      = x1_q;
    assign x1_rise = x1_rise_q;
    assign x1_fall = x1_fall_q;

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    logic                glitch;
    logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;

    // A glitch is a wait state abandoned because s2 returned to the old level.
    always_comb begin
        glitch       = ((state_q == ST_RISE_WAIT) && !s2_q) ||
                       ((state_q == ST_FALL_WAIT) &&  s2_q);
        glitch_cnt_d = glitch_cnt_q;
        if (glitch && (glitch_cnt_q != {GLITCH_W{1'b1}})) begin
            glitch_cnt_d = glitch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: two instances (debounce 16 and debounce 1) share
// din/reset and are compared every cycle against a run-length reference model.
module tb_input_conditioner;

    logic clk;
    logic reset;
    logic din;
    logic x1_o   [2];
    logic rise_o [2];
    logic fall_o [2];
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    logic [7:0] gc_o [2];
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state per instance.
    int dval   [2] = '{16, 1};
    int m_s1   [2];
    int m_s2   [2];
    int m_lvl  [2];
    int m_run  [2];
    int m_rise [2];
    int m_fall [2];
    int m_gc   [2];

    input_conditioner #(.DEBOUNCE_CYCLES(16), .CNT_W(5), .GLITCH_W(8)) u_dut16 (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .x1         (x1_o[0]),
        .x1_rise    (rise_o[0]),
        .x1_fall    (fall_o[0])
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
        ,
        .glitch_cnt (gc_o[0])
`endif
    );

    input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(5), .GLITCH_W(8)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .x1         (x1_o[1]),
        .x1_rise    (rise_o[1]),
        .x1_fall    (fall_o[1])
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
        ,
        .glitch_cnt (gc_o[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: after synchronisation, a level change is accepted once DEBOUNCE+1
    // consecutive samples differ from the current level; an earlier return to
    // the current level is a glitch.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
                m_rise[i] = 0; m_fall[i] = 0; m_gc[i] = 0;
            end else begin
                int smp;
                smp = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(din);
                m_rise[i] = 0;
                m_fall[i] = 0;
                if (smp != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == dval[i] + 1) begin
                        m_lvl[i] = smp;
                        m_run[i] = 0;
                        if (smp == 1) m_rise[i] = 1;
                        else          m_fall[i] = 1;
                    end
                end else if (m_run[i] > 0) begin
                    m_run[i] = 0;
                    if (m_gc[i] < 255) m_gc[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "x1_d16"   : "x1_d1",   int'(x1_o[i]),   m_lvl[i]);
            chk(i == 0 ? "rise_d16" : "rise_d1", int'(rise_o[i]), m_rise[i]);
            chk(i == 0 ? "fall_d16" : "fall_d1", int'(fall_o[i]), m_fall[i]);
            chk(i == 0 ? "both_d16" : "both_d1", int'(rise_o[i] & fall_o[i]), 0);
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
            chk(i == 0 ? "gcnt_d16" : "gcnt_d1", int'(gc_o[i]), m_gc[i]);
`endif
        end
    endtask

    // Drive din from the first step, return edges until each x1 reaches lvl.
    task automatic measure(input logic lvl, output int lat16, output int lat1);
        lat16 = -1;
        lat1  = -1;
        din = lvl;
        for (int k = 0; k < 40; k++) begin
            step();
            if (lat16 < 0 && x1_o[0] == lvl) lat16 = k;
            if (lat1  < 0 && x1_o[1] == lvl) lat1  = k;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        int l16, l1;
        int stayed_low;
        reset = 1'b1;
        din   = 1'b0;
        @(negedge clk);
        din = 1'b1;   // reset must dominate din
        repeat (3) step();
        chk("rst_x1", int'(x1_o[0]), 0);
        chk("rst_rise", int'(rise_o[0]), 0);
        reset = 1'b0;
        din   = 1'b0;
        repeat (9) step();

        // Rising latency: din=1 from edge N -> x1 after edge N+2+D.
        measure(1'b1, l16, l1);
        chk("rise_lat_d16", l16, 18);
        chk("rise_lat_d1",  l1,  3);
        // Falling latency, symmetric.
        measure(1'b0, l16, l1);
        chk("fall_lat_d16", l16, 18);
        chk("fall_lat_d1",  l1,  3);

        // Short 5-cycle pulse is rejected by the 16-cycle debouncer.
        stayed_low = 1;
        din = 1'b1;
        repeat (5) step();
        din = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (x1_o[0] != 1'b0) stayed_low = 0;
        end
        chk("pulse_reject", stayed_low, 1);

        // Chatter every 3 cycles, then held high.
        for (int k = 0; k < 60; k++) begin
            din = ((k / 3) % 2 == 0);
            step();
        end
        din = 1'b1;
        repeat (40) step();
        chk("chatter_high", int'(x1_o[0]), 1);

        // Reset pulse while HIGH with din still 1.
        reset = 1'b1;
        step();
        chk("rst_in_high_x1", int'(x1_o[0]), 0);
        chk("rst_in_high_fall", int'(fall_o[0]), 0);
        reset = 1'b0;
        repeat (30) step();
        chk("post_rst_high", int'(x1_o[0]), 1);

        // Random level segments with occasional reset.
        for (int s = 0; s < 300; s++) begin
            int len;
            din = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 22);
            reset = ($urandom_range(0, 39) == 0);
            step();
            reset = 1'b0;
            repeat (len - 1) step();
        end

        // Sustained chatter to drive the glitch counter past saturation.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 1400; k++) begin
            din = ((k / 2) % 2 == 0);
            step();
        end
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
        chk("gcnt_saturated", int'(gc_o[0]), 255);
`endif
        din = 1'b0;
        repeat (30) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
